// File: rtl/qei_pkg.sv
// Shared constants and transition classification for the quadrature decoder.
// The filtered pair is packed as {A,B}; forward order is 00->01->11->10->00.
package qei_pkg;

    localparam logic [1:0] QEI_X1 = 2'd0;
    localparam logic [1:0] QEI_X2 = 2'd1;
    localparam logic [1:0] QEI_X4 = 2'd2;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic [1:0] {
        TR_NONE,
        TR_FWD,
        TR_REV,
        TR_ILLEGAL
    } qei_trans_e;

    function automatic logic [1:0] qei_fwd_next(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b11;
            2'b11:   nxt = 2'b10;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    function automatic qei_trans_e qei_classify(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        qei_trans_e tr;
        if (cur_ab == prev_ab)
            tr = TR_NONE;
        else if (cur_ab == qei_fwd_next(prev_ab))
            tr = TR_FWD;
        else if (prev_ab == qei_fwd_next(cur_ab))
            tr = TR_REV;
        else
            tr = TR_ILLEGAL;
        return tr;
    endfunction

endpackage

// File: rtl/qei_if.sv
// Control/status bundle for one quadrature decoder channel.
// master = the controlling side (drives encoder lines and requests), slave = the decoder view.
interface qei_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             a_in;
    logic             b_in;
    logic             idx_in;
    logic [1:0]       mode;
    logic             idx_clr_en;
    logic             cnt_load;
    logic [CNT_W-1:0] load_val;
    logic             latch_req;
    logic             err_clr;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic             step;
    logic             err;
    logic [CNT_W-1:0] latch_cnt;
    logic             latch_valid;

    modport master (
        output en, a_in, b_in, idx_in, mode, idx_clr_en, cnt_load, load_val, latch_req, err_clr,
        input  count, dir, step, err, latch_cnt, latch_valid
    );

    modport slave (
        input  en, a_in, b_in, idx_in, mode, idx_clr_en, cnt_load, load_val, latch_req, err_clr,
        output count, dir, step, err, latch_cnt, latch_valid
    );
endinterface

// File: rtl/qei_sync_filt.sv
// Synchroniser chain followed by a run-length filter: the output only takes a level
// after FILT_LEN consecutive identical synchronised samples. valid marks the first acceptance.
module qei_sync_filt #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic valid
);

    localparam int RUN_W = $clog2(FILT_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILT_LEN);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_out;
    logic                   cand_reg;
    logic [RUN_W-1:0]       run_reg;
    logic [RUN_W-1:0]       run_next;
    logic                   out_reg;
    logic                   valid_reg;

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // Run length of the current candidate level, including this cycle's sample.
    always_comb begin
        run_next = RUN_W'(1);
        if (sync_out == cand_reg) begin
            if (run_reg == RUN_MAX)
                run_next = RUN_MAX;
            else
                run_next = run_reg + RUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= '0;
            cand_reg  <= 1'b0;
            run_reg   <= '0;
            out_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            cand_reg <= sync_out;
            run_reg  <= run_next;
            if (run_next == RUN_MAX) begin
                out_reg   <= sync_out;
                valid_reg <= 1'b1;
            end
        end
    end

    assign dout  = out_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/qei_core.sv
// Quadrature encoder decoder: filtered A/B/index inputs, x1/x2/x4 counting,
// index clear, preset, sticky illegal-transition flag and count snapshot.
module qei_core #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             idx_in,
    input  logic [1:0]       mode,
    input  logic             idx_clr_en,
    input  logic             cnt_load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             latch_req,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic [CNT_W-1:0] latch_cnt,
    output logic             latch_valid
);
    import qei_pkg::*;

    logic [2:0] raw_in;
    logic [2:0] filt;
    logic [2:0] filt_valid;

    assign raw_in = {idx_in, b_in, a_in};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_in
            qei_sync_filt #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_LEN    (FILT_LEN)
            ) u_filt (
                .clk   (clk),
                .rst   (rst),
                .din   (raw_in[gi]),
                .dout  (filt[gi]),
                .valid (filt_valid[gi])
            );
        end
    endgenerate

    logic [1:0]       ab_cur;
    logic [1:0]       prev_ab_reg;
    logic             idx_prev_reg;
    logic             first_reg;
    logic             first_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             dir_reg;
    logic             dir_next;
    logic             step_reg;
    logic             step_next;
    logic             err_reg;
    logic             err_next;
    logic [CNT_W-1:0] latch_cnt_reg;
    logic             latch_valid_reg;

    qei_trans_e trans;
    logic       active;
    logic       counted;
    logic       idx_clr;

    assign ab_cur = {filt[0], filt[1]};

    always_comb begin
        trans      = qei_classify(prev_ab_reg, ab_cur);
        // Decoding is live only once both A and B have been qualified after reset.
        active     = en && !first_reg;
        first_next = first_reg && !(filt_valid[0] && filt_valid[1]);
        idx_clr    = en && idx_clr_en && filt_valid[2] && filt[2] && !idx_prev_reg;

        case (mode)
            QEI_X1:  counted = (ab_cur == 2'b11);
            QEI_X2:  counted = (ab_cur == 2'b11) || (ab_cur == 2'b00);
            default: counted = 1'b1;
        endcase

        step_next = active && counted && ((trans == TR_FWD) || (trans == TR_REV));
        dir_next  = dir_reg;
        if (step_next)
            dir_next = (trans == TR_FWD) ? DIR_FWD : DIR_REV;

        // A fresh illegal transition wins over a same-cycle clear.
        err_next = err_reg;
        if (active && (trans == TR_ILLEGAL))
            err_next = 1'b1;
        else if (err_clr)
            err_next = 1'b0;

        count_next = count_reg;
        if (cnt_load)
            count_next = load_val;
        else if (idx_clr)
            count_next = '0;
        else if (step_next)
            count_next = (trans == TR_FWD) ? count_reg + CNT_W'(1) : count_reg - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ab_reg     <= 2'b00;
            idx_prev_reg    <= 1'b0;
            first_reg       <= 1'b1;
            count_reg       <= '0;
            dir_reg         <= 1'b0;
            step_reg        <= 1'b0;
            err_reg         <= 1'b0;
            latch_cnt_reg   <= '0;
            latch_valid_reg <= 1'b0;
        end else begin
            // Previous state always follows the filters, so re-enabling never sees a stale pair.
            prev_ab_reg     <= ab_cur;
            idx_prev_reg    <= filt[2];
            first_reg       <= first_next;
            count_reg       <= count_next;
            dir_reg         <= dir_next;
            step_reg        <= step_next;
            err_reg         <= err_next;
            latch_valid_reg <= latch_req;
            if (latch_req)
                latch_cnt_reg <= count_reg;
        end
    end

    assign count       = count_reg;
    assign dir         = dir_reg;
    assign step        = step_reg;
    assign err         = err_reg;
    assign latch_cnt   = latch_cnt_reg;
    assign latch_valid = latch_valid_reg;

endmodule

// File: tb/tb_qei_core.sv
// Directed bench for qei_core at default parameters: vector table plus timed
// sequences for latency, wrap, index/load priority, snapshot, reset and enable.
module tb_qei_core;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    qei_if #(.CNT_W(16)) bus ();

    qei_core dut (
        .clk         (clk),
        .rst         (rst),
        .en          (bus.en),
        .a_in        (bus.a_in),
        .b_in        (bus.b_in),
        .idx_in      (bus.idx_in),
        .mode        (bus.mode),
        .idx_clr_en  (bus.idx_clr_en),
        .cnt_load    (bus.cnt_load),
        .load_val    (bus.load_val),
        .latch_req   (bus.latch_req),
        .err_clr     (bus.err_clr),
        .count       (bus.count),
        .dir         (bus.dir),
        .step        (bus.step),
        .err         (bus.err),
        .latch_cnt   (bus.latch_cnt),
        .latch_valid (bus.latch_valid)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  ab;
        logic [15:0] exp_cnt;
        logic        exp_dir;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic set_ab(input logic [1:0] ab);
        bus.a_in = ab[1];
        bus.b_in = ab[0];
    endtask

    task automatic load(input logic [15:0] v);
        bus.load_val = v;
        bus.cnt_load = 1'b1;
        tick(1);
        bus.cnt_load = 1'b0;
    endtask

    logic [1:0] fwd_seq[4];
    logic [1:0] rev_seq[4];
    int         pulses;

    initial begin
        fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        rev_seq = '{2'b10, 2'b11, 2'b01, 2'b00};

        // {mode, ab, count, dir, err}; starts from ab=00, count=4, dir=0
        vecs[0]  = '{2'd1, 2'b01, 16'd4, 1'b0, 1'b0};
        vecs[1]  = '{2'd1, 2'b11, 16'd5, 1'b1, 1'b0};
        vecs[2]  = '{2'd1, 2'b10, 16'd5, 1'b1, 1'b0};
        vecs[3]  = '{2'd1, 2'b00, 16'd6, 1'b1, 1'b0};
        vecs[4]  = '{2'd1, 2'b10, 16'd6, 1'b1, 1'b0};
        vecs[5]  = '{2'd1, 2'b11, 16'd5, 1'b0, 1'b0};
        vecs[6]  = '{2'd3, 2'b01, 16'd4, 1'b0, 1'b0};
        vecs[7]  = '{2'd3, 2'b00, 16'd3, 1'b0, 1'b0};
        vecs[8]  = '{2'd3, 2'b01, 16'd4, 1'b1, 1'b0};
        vecs[9]  = '{2'd0, 2'b00, 16'd4, 1'b1, 1'b0};
        vecs[10] = '{2'd2, 2'b11, 16'd4, 1'b1, 1'b1};
        vecs[11] = '{2'd2, 2'b10, 16'd5, 1'b1, 1'b1};

        bus.en = 1'b1;  bus.a_in = 1'b0; bus.b_in = 1'b0; bus.idx_in = 1'b0;
        bus.mode = 2'd2; bus.idx_clr_en = 1'b0; bus.cnt_load = 1'b0; bus.load_val = '0;
        bus.latch_req = 1'b0; bus.err_clr = 1'b0;

        tick(3);
        rst = 1'b0;
        chk("reset_count", bus.count, 0);
        chk("reset_dir", bus.dir, 0);
        chk("reset_step", bus.step, 0);
        chk("reset_err", bus.err, 0);
        chk("reset_latch_cnt", bus.latch_cnt, 0);
        chk("reset_latch_valid", bus.latch_valid, 0);
        tick(10);

        // x4 forward cycle: count lands exactly 7 edges after each input change
        for (int i = 0; i < 4; i++) begin
            set_ab(fwd_seq[i]);
            tick(6);
            chk("x4_step_early", bus.step, 0);
            chk("x4_count_early", bus.count, i);
            tick(1);
            chk("x4_step_pulse", bus.step, 1);
            chk("x4_count", bus.count, i + 1);
            chk("x4_dir", bus.dir, 1);
            tick(1);
            chk("x4_step_end", bus.step, 0);
            $display("x4 fwd ab=%b count=%0d", fwd_seq[i], bus.count);
        end

        // x1: eight forward then eight backward cycles
        bus.mode = 2'd0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) begin set_ab(fwd_seq[i]); tick(10); end
            chk("x1_fwd_count", bus.count, 5 + c);
        end
        chk("x1_fwd_dir", bus.dir, 1);
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) begin set_ab(rev_seq[i]); tick(10); end
            chk("x1_rev_count", bus.count, 11 - c);
        end
        chk("x1_rev_dir", bus.dir, 0);
        $display("x1 round trip count=%0d dir=%0d", bus.count, bus.dir);

        for (int v = 0; v < 12; v++) begin
            bus.mode = vecs[v].mode;
            set_ab(vecs[v].ab);
            tick(10);
            chk($sformatf("vec%0d_count", v), bus.count, vecs[v].exp_cnt);
            chk($sformatf("vec%0d_dir", v), bus.dir, vecs[v].exp_dir);
            chk($sformatf("vec%0d_err", v), bus.err, vecs[v].exp_err);
            $display("vec %0d mode=%0d ab=%b count=%0d dir=%0d err=%0d",
                     v, vecs[v].mode, vecs[v].ab, bus.count, bus.dir, bus.err);
        end

        bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
        chk("err_clear", bus.err, 0);

        // 3-cycle glitch on A (state 10) must be filtered out
        bus.a_in = 1'b0; tick(3); bus.a_in = 1'b1; tick(10);
        chk("glitch_count", bus.count, 5);
        chk("glitch_err", bus.err, 0);
        $display("glitch count=%0d err=%0d", bus.count, bus.err);

        // illegal 10->01 with err_clr in the same cycle: err stays set
        set_ab(2'b01); tick(6);
        bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
        chk("err_clr_race_err", bus.err, 1);
        chk("err_clr_race_count", bus.count, 5);
        bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
        chk("err_clear2", bus.err, 0);

        // wrap both ways
        bus.mode = 2'd2;
        load(16'hFFFF);
        chk("load_ffff", bus.count, 16'hFFFF);
        set_ab(2'b11); tick(10);
        chk("wrap_up", bus.count, 16'h0000);
        set_ab(2'b01); tick(10);
        chk("wrap_down", bus.count, 16'hFFFF);
        chk("wrap_down_dir", bus.dir, 0);
        $display("wrap count=0x%0h", bus.count);

        // index edge coincident with a forward step at 37
        load(16'd37);
        bus.idx_clr_en = 1'b1;
        set_ab(2'b11); bus.idx_in = 1'b1;
        tick(6);
        chk("idx_pre_count", bus.count, 37);
        tick(1);
        chk("idx_clr_count", bus.count, 0);
        chk("idx_clr_step", bus.step, 1);
        chk("idx_clr_dir", bus.dir, 1);
        bus.idx_in = 1'b0; tick(10);
        // load coincident with the filtered index edge wins
        bus.idx_in = 1'b1; tick(6);
        bus.load_val = 16'h1234; bus.cnt_load = 1'b1; tick(1); bus.cnt_load = 1'b0;
        chk("load_vs_idx", bus.count, 16'h1234);
        tick(4);
        chk("load_vs_idx_hold", bus.count, 16'h1234);
        bus.idx_clr_en = 1'b0; bus.idx_in = 1'b0; tick(10);
        $display("index/load count=0x%0h", bus.count);

        // snapshot coincident with a step captures the pre-step value
        load(16'd100);
        set_ab(2'b10); tick(6);
        bus.latch_req = 1'b1; tick(1); bus.latch_req = 1'b0;
        chk("latch_valid", bus.latch_valid, 1);
        chk("latch_cnt", bus.latch_cnt, 100);
        chk("latch_count_after", bus.count, 101);
        tick(1);
        chk("latch_valid_end", bus.latch_valid, 0);
        $display("latch latch_cnt=%0d count=%0d", bus.latch_cnt, bus.count);

        // reset mid-dwell with inputs at 10
        tick(2);
        rst = 1'b1; tick(1);
        chk("rst_mid_count", bus.count, 0);
        chk("rst_mid_dir", bus.dir, 0);
        chk("rst_mid_step", bus.step, 0);
        chk("rst_mid_err", bus.err, 0);
        chk("rst_mid_latch_cnt", bus.latch_cnt, 0);
        chk("rst_mid_latch_valid", bus.latch_valid, 0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin tick(1); if (bus.step) pulses++; end
        chk("rst_first_no_step", pulses, 0);
        chk("rst_first_count", bus.count, 0);
        chk("rst_first_err", bus.err, 0);
        set_ab(2'b00); tick(10);
        chk("rst_next_count", bus.count, 1);
        chk("rst_next_dir", bus.dir, 1);
        $display("post-reset count=%0d", bus.count);

        // disabled: filters track, nothing counts, no spurious step on re-enable
        bus.en = 1'b0;
        set_ab(2'b01);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin tick(1); if (bus.step) pulses++; end
        chk("dis_no_step", pulses, 0);
        chk("dis_count", bus.count, 1);
        bus.en = 1'b1; tick(10);
        chk("reen_count", bus.count, 1);
        set_ab(2'b11); tick(10);
        chk("reen_step_count", bus.count, 2);
        $display("enable count=%0d", bus.count);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
